// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the 2-way write-through data cache.
// Address decode is relative to the data region base.
package cache_pkg;

    localparam logic [31:0] BASE_ADDR = 32'd1024;
    localparam int SETS   = 64;
    localparam int OFF_W  = 3;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = 9;
    localparam int CA_MSB = OFF_W + IDX_W + TAG_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE_THRU
    } state_t;

endpackage

// File: rtl/cache_if.sv
// Pipeline-side request bus and SRAM-controller bus of the data cache.
// slave = cache controller, master = pipeline plus SRAM controller.
interface cache_if;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read;
    logic        sram_write;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  mem_r_en, mem_w_en, address, wdata,
        input  sram_rdata, sram_ready,
        output rdata, ready,
        output sram_address, sram_wdata, sram_read, sram_write
    );

    modport master (
        output mem_r_en, mem_w_en, address, wdata,
        output sram_rdata, sram_ready,
        input  rdata, ready,
        input  sram_address, sram_wdata, sram_read, sram_write
    );

endinterface

// File: rtl/cache_way.sv
// One cache way: valid, tag and a two-word line per set.
// Read port is combinational; fill, word update and invalidate on clk.
module cache_way
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             fill_i,
    input  logic [63:0]      line_i,
    input  logic             upd_i,
    input  logic             wsel_i,
    input  logic [31:0]      word_i,
    input  logic             inv_i,
    output logic             hit_o,
    output logic [63:0]      line_o
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [63:0]      data_q [SETS];

    assign hit_o  = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign line_o = data_q[idx_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
        end else if (inv_i) begin
            valid_q[idx_i] <= 1'b0;
        end
    end

    // Tags and data need no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= line_i;
        end else if (upd_i) begin
            if (wsel_i) data_q[idx_i][63:32] <= word_i;
            else        data_q[idx_i][31:0]  <= word_i;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-allocate data cache controller.
// Define CACHE_WRITE_UPDATE_EN to update hit lines on stores instead of invalidating.
module cache_controller
    import cache_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    cache_if.slave  bus
);

    state_t             state_q;
    logic [SETS-1:0]    lru_q;
    logic [CA_MSB-OFF_W:0] ca_hi;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               wsel;
    logic               hit0, hit1, hit;
    logic [63:0]        line0, line1, hit_line;
    logic               fill_w, wdone_w;
    logic               fill0, fill1;
    logic               upd0, upd1, inv0, inv1;

    // Base has no bits below the index, so only the upper part is offset.
    assign ca_hi = bus.address[CA_MSB:OFF_W] - BASE_ADDR[CA_MSB:OFF_W];
    assign idx   = ca_hi[IDX_W-1:0];
    assign tag   = ca_hi[IDX_W +: TAG_W];
    assign wsel  = bus.address[2];

    assign hit      = hit0 | hit1;
    assign hit_line = hit1 ? line1 : line0;

    assign fill_w  = (state_q == READ_MISS) && bus.sram_ready;
    assign wdone_w = (state_q == WRITE_THRU) && bus.sram_ready;
    assign fill0   = fill_w && !lru_q[idx];
    assign fill1   = fill_w &&  lru_q[idx];

`ifdef CACHE_WRITE_UPDATE_EN
    assign upd0 = wdone_w && hit0;
    assign upd1 = wdone_w && hit1;
    assign inv0 = 1'b0;
    assign inv1 = 1'b0;
`else
    assign upd0 = 1'b0;
    assign upd1 = 1'b0;
    assign inv0 = wdone_w && hit0;
    assign inv1 = wdone_w && hit1;
`endif

    cache_way u_way0 (
        .clk(clk), .rst(rst), .idx_i(idx), .tag_i(tag),
        .fill_i(fill0), .line_i(bus.sram_rdata),
        .upd_i(upd0), .wsel_i(wsel), .word_i(bus.wdata),
        .inv_i(inv0), .hit_o(hit0), .line_o(line0)
    );

    cache_way u_way1 (
        .clk(clk), .rst(rst), .idx_i(idx), .tag_i(tag),
        .fill_i(fill1), .line_i(bus.sram_rdata),
        .upd_i(upd1), .wsel_i(wsel), .word_i(bus.wdata),
        .inv_i(inv1), .hit_o(hit1), .line_o(line1)
    );

    always_comb begin
        bus.ready        = 1'b0;
        bus.rdata        = '0;
        bus.sram_read    = 1'b0;
        bus.sram_write   = 1'b0;
        bus.sram_address = '0;
        bus.sram_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (bus.mem_r_en) begin
                    bus.ready = hit;
                    if (hit)
                        bus.rdata = wsel ? hit_line[63:32] : hit_line[31:0];
                end else begin
                    bus.ready = !bus.mem_w_en;
                end
            end
            READ_MISS: begin
                bus.sram_read    = !bus.sram_ready;
                bus.sram_address = {bus.address[31:3], 1'b0, bus.address[1:0]};
                bus.ready        = bus.sram_ready;
                if (bus.sram_ready)
                    bus.rdata = wsel ? bus.sram_rdata[63:32]
                                     : bus.sram_rdata[31:0];
            end
            WRITE_THRU: begin
                bus.sram_write   = 1'b1;
                bus.sram_address = bus.address;
                bus.sram_wdata   = bus.wdata;
                bus.ready        = bus.sram_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lru_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_r_en) begin
                        if (hit) lru_q[idx] <= hit0;
                        else     state_q    <= READ_MISS;
                    end else if (bus.mem_w_en) begin
                        state_q <= WRITE_THRU;
                    end
                end
                READ_MISS: begin
                    if (bus.sram_ready) begin
                        lru_q[idx] <= ~lru_q[idx];
                        state_q    <= IDLE;
                    end
                end
                WRITE_THRU: begin
                    if (bus.sram_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a set/way/LRU reference model
// and a backing-memory model; outputs are compared on every falling edge.
module tb_cache_controller;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_if bus ();

    cache_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    bit         mv [64][2];
    bit [8:0]   mt [64][2];
    bit         ml [64];
    logic [31:0] mem [logic [31:0]];

    bit          chk_en;
    logic        e_ready, e_rd_chk, e_sr, e_sw;
    logic [31:0] e_rdata, e_saddr, e_swdata;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] memrd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h5A5A0000 ^ a;
    endfunction

    function automatic int idx_of(logic [31:0] a);
        logic [31:0] ca;
        ca = a - 32'd1024;
        return int'(ca[8:3]);
    endfunction

    function automatic bit [8:0] tag_of(logic [31:0] a);
        logic [31:0] ca;
        ca = a - 32'd1024;
        return ca[17:9];
    endfunction

    function automatic int way_hit(logic [31:0] a);
        int s;
        s = idx_of(a);
        for (int w = 0; w < 2; w++)
            if (mv[s][w] && mt[s][w] == tag_of(a)) return w;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 1'b0;
            mv[s][1] = 1'b0;
            ml[s]    = 1'b0;
        end
    endfunction

    task automatic idle_exp();
        e_ready  = 1'b1;
        e_rd_chk = 1'b0;
        e_sr     = 1'b0;
        e_sw     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(bus.ready), 32'(e_ready));
            if (e_rd_chk) chk("rdata", bus.rdata, e_rdata);
            chk("sram_read", 32'(bus.sram_read), 32'(e_sr));
            chk("sram_write", 32'(bus.sram_write), 32'(e_sw));
            if (e_sr || e_sw) chk("sram_address", bus.sram_address, e_saddr);
            if (e_sw) chk("sram_wdata", bus.sram_wdata, e_swdata);
        end
    end

    task automatic do_read(input logic [31:0] a, input bit also_w,
                           output bit got_hit, output logic [31:0] got_data);
        int s, w, lw;
        logic [31:0] la;
        s  = idx_of(a);
        w  = way_hit(a);
        la = a & ~32'd4;
        bus.address    = a;
        bus.mem_r_en   = 1'b1;
        bus.mem_w_en   = also_w;
        bus.wdata      = 32'hDEAD0000;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = {memrd(la + 32'd4), memrd(la)};
        e_sr = 1'b0;
        e_sw = 1'b0;
        e_ready  = (w >= 0);
        e_rd_chk = (w >= 0);
        e_rdata  = memrd(a);
        @(negedge clk);
        got_hit  = bus.ready;
        got_data = bus.rdata;
        @(posedge clk); #1;
        if (w >= 0) begin
            ml[s] = (w == 0);
        end else begin
            for (int k = 1; k <= LAT; k++) begin
                bus.sram_ready = (k == LAT);
                e_sr     = (k != LAT);
                e_saddr  = la;
                e_ready  = (k == LAT);
                e_rd_chk = (k == LAT);
                @(negedge clk);
                if (k == LAT) got_data = bus.rdata;
                @(posedge clk); #1;
            end
            lw = int'(ml[s]);
            mv[s][lw] = 1'b1;
            mt[s][lw] = tag_of(a);
            ml[s]     = ~ml[s];
        end
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.sram_ready = 1'b0;
        idle_exp();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int s, w;
        s = idx_of(a);
        w = way_hit(a);
        bus.address    = a;
        bus.wdata      = d;
        bus.mem_w_en   = 1'b1;
        bus.mem_r_en   = 1'b0;
        bus.sram_ready = 1'b0;
        e_ready  = 1'b0;
        e_rd_chk = 1'b0;
        e_sr     = 1'b0;
        e_sw     = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= LAT; k++) begin
            bus.sram_ready = (k == LAT);
            e_sw     = 1'b1;
            e_saddr  = a;
            e_swdata = d;
            e_ready  = (k == LAT);
            @(posedge clk); #1;
        end
        mem[a] = d;
`ifndef CACHE_WRITE_UPDATE_EN
        if (w >= 0) mv[s][w] = 1'b0;
`endif
        bus.mem_w_en   = 1'b0;
        bus.sram_ready = 1'b0;
        idle_exp();
    endtask

    task automatic rst_mid(input logic [31:0] a);
        logic [31:0] la;
        la = a & ~32'd4;
        bus.address    = a;
        bus.mem_r_en   = 1'b1;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = {memrd(la + 32'd4), memrd(la)};
        e_ready  = 1'b0;
        e_rd_chk = 1'b0;
        e_sr     = 1'b0;
        @(posedge clk); #1;
        e_sr    = 1'b1;
        e_saddr = la;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.mem_r_en = 1'b0;
        model_reset();
        idle_exp();
        e_rd_chk = 1'b1;
        e_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_exp();
    endtask

    bit          h;
    logic [31:0] d;

    initial begin
        rst            = 1'b1;
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.address    = '0;
        bus.wdata      = '0;
        bus.sram_rdata = '0;
        bus.sram_ready = 1'b0;
        model_reset();
        mem[32'd1024] = 32'hAAAA0001;
        mem[32'd1028] = 32'hBBBB0002;
        idle_exp();
        e_rd_chk = 1'b1;
        e_rdata  = 32'h0;
        chk_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_exp();

        bus.sram_ready = 1'b1;
        @(posedge clk); #1;
        bus.sram_ready = 1'b0;
        @(posedge clk); #1;

        do_read(32'd1024, 1'b0, h, d);
        chk("cold_hit", 32'(h), 32'd0);
        chk("cold_data", d, 32'hAAAA0001);
        do_read(32'd1028, 1'b0, h, d);
        chk("reread_hit", 32'(h), 32'd1);
        chk("reread_data", d, 32'hBBBB0002);

        do_read(32'd1536, 1'b0, h, d);
        chk("lru_b_hit", 32'(h), 32'd0);
        do_read(32'd2048, 1'b0, h, d);
        chk("lru_c_hit", 32'(h), 32'd0);
        do_read(32'd1536, 1'b0, h, d);
        chk("lru_b_again", 32'(h), 32'd1);
        do_read(32'd1024, 1'b0, h, d);
        chk("lru_a_evicted", 32'(h), 32'd0);
        chk("lru_a_data", d, 32'hAAAA0001);

        do_write(32'd1028, 32'h12345678);
        do_read(32'd1028, 1'b0, h, d);
`ifdef CACHE_WRITE_UPDATE_EN
        chk("wr_hit_read", 32'(h), 32'd1);
`else
        chk("wr_hit_read", 32'(h), 32'd0);
`endif
        chk("wr_hit_data", d, 32'h12345678);

        do_write(32'd4096, 32'hCAFEF00D);
        do_read(32'd4096, 1'b0, h, d);
        chk("wr_miss_read", 32'(h), 32'd0);
        chk("wr_miss_data", d, 32'hCAFEF00D);

        rst_mid(32'd1100);
        do_read(32'd1100, 1'b0, h, d);
        chk("rst_reread", 32'(h), 32'd0);
        chk("rst_data", d, 32'h5A5A044C);

        do_read(32'd1200, 1'b1, h, d);
        chk("both_en_hit", 32'(h), 32'd0);
        do_read(32'd1204, 1'b0, h, d);
        chk("odd_hit", 32'(h), 32'd1);
        chk("odd_data", d, 32'h5A5A04B4);

        do_read(32'd1024, 1'b0, h, d);
        chk("after_rst_a", 32'(h), 32'd0);
        do_read(32'd1028, 1'b0, h, d);
        chk("final_hit", 32'(h), 32'd1);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port mem_r_en, input, 1: memory-stage load request, held until ready.
REQ-004 SHALL have port mem_w_en, input, 1: memory-stage store request, held until ready.
REQ-005 SHALL have port address, input, 32: byte address of the request (data region starts at 1024).
REQ-006 SHALL have port wdata, input, 32: store data.
REQ-007 SHALL have port rdata, output, 32: load result, valid while ready=1 with mem_r_en.
REQ-008 SHALL have port ready, output, 1: request complete; low freezes the pipeline.
REQ-009 SHALL have port sram_address, output, 32: address to the SRAM controller.
REQ-010 SHALL have port sram_wdata, output, 32: store data to the SRAM controller.
REQ-011 SHALL have ports sram_read and sram_write, output, 1 each: SRAM controller read and write enables.
REQ-012 SHALL have port sram_rdata, input, 64: fetched line; [31:0] is the even word, [63:32] the odd word.
REQ-013 SHALL have port sram_ready, input, 1: one-cycle SRAM completion pulse.

Function
REQ-014 SHALL form the cache address ca = address - 1024 and decode it as follows:
- ca[2]: word select.
- ca[8:3]: set index (64 sets).
- ca[17:9]: tag (9 bits).
REQ-015 SHALL be 2-way set-associative: per way and set, valid + 9-bit tag + two 32-bit words; per set, one LRU bit naming the least-recently-used way.
REQ-016 SHALL implement FSM states IDLE, READ_MISS and WRITE_THRU.
REQ-017 SHALL handle a read hit in IDLE (valid && tag match in either way) combinationally:
- ready=1 and rdata = the selected word in the same cycle, no SRAM access.
- LRU bit set to the other way at the clock edge.
REQ-018 SHALL handle a read miss as follows:
- IDLE -> READ_MISS.
- sram_read=1 and sram_address = address with bit2 cleared while in READ_MISS.
- ready=0 until sram_ready.
REQ-019 SHALL handle the sram_ready cycle in READ_MISS as follows:
- Same cycle: ready=1, rdata = sram_rdata word chosen by ca[2], sram_read=0.
- Next edge: fill the LRU way (tag, both words, valid=1), flip LRU, return to IDLE.
REQ-020 SHALL handle a write as write-through, no-allocate:
- IDLE -> WRITE_THRU.
- sram_write=1, sram_address=address, sram_wdata=wdata.
- ready=1 only in the sram_ready cycle, then IDLE.
REQ-021 SHALL, on a write hit, apply the Configuration behaviour on the sram_ready edge; a write miss SHALL leave the arrays unchanged.
REQ-022 SHALL give mem_r_en priority over mem_w_en when both are high.
REQ-023 SHALL drive ready=1 in IDLE when neither enable is high, and sram_read=sram_write=0 outside READ_MISS/WRITE_THRU.
REQ-024 SHALL ignore sram_ready in IDLE.
REQ-025 SHALL, with both ways valid on a hit, select the matching way; matches on both ways are impossible by construction.

Reset
REQ-026 SHALL, on rst, asynchronously set state=IDLE and clear all valid bits and all LRU bits (LRU -> way 0); tag and data contents are don't-care.
REQ-027 SHALL, while rst is high, drive ready=1 if no enable is high, sram_read=0, sram_write=0, rdata=0.
REQ-028 SHALL abandon a miss interrupted by rst mid-operation with no array update; the next request restarts from IDLE.

Configuration
REQ-029 SHALL, with CACHE_WRITE_UPDATE_EN defined, update the selected word of the hit way on a write hit, with valid and LRU unchanged.
REQ-030 SHALL, without CACHE_WRITE_UPDATE_EN, clear the valid bit of the hit way on a write hit.

Structure
REQ-031 SHALL place in shared package cache_pkg:
- Constants for the 1024 data-region base address, the set count, and the tag/index/offset widths.
- The FSM state typedef.
REQ-032 SHALL implement per-way storage (valid, tag, two words, read port, fill/update/invalidate write port) as sub-module cache_way, instantiated twice.

Verification
REQ-033 SHALL cover a cold read: after reset, read 1024 with SRAM line {0xBBBB0002, 0xAAAA0001} -> miss, one sram_read burst, rdata=0xAAAA0001 on sram_ready; an immediate re-read of 1028 -> hit, same cycle, rdata=0xBBBB0002.
REQ-034 SHALL cover LRU: read 1024, 1536, then 2048 (all set 0, distinct tags) -> the third fill evicts the 1024 line; re-reading 1024 misses, re-reading 1536 hits.
REQ-035 SHALL cover write hit: write 0x12345678 to 1028 after filling 1024 -> one sram_write burst. Then read 1028:
- With CACHE_WRITE_UPDATE_EN: hit, returns 0x12345678.
- Without it: miss.
REQ-036 SHALL cover a write miss to 4096 -> sram_write asserted, ready only on sram_ready, and a following read of 4096 misses.
REQ-037 SHALL cover rst asserted two cycles into a READ_MISS -> state IDLE, no fill, and re-reading the same address misses.
REQ-038 SHALL cover mem_r_en and mem_w_en high together on a miss address -> READ_MISS entered, sram_write stays 0.
